// File: rtl/iq_payload_ram_cfg.sv
// iq_payload_ram_cfg: partition-aware multi-port issue-queue payload RAM with sequential init sweep
module iq_payload_ram_cfg #(
  parameter int DEPTH    = 64,
  parameter int INDEX    = 6,
  parameter int WIDTH    = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 4,
  parameter int PARTS    = 4,
  parameter int PART_LOG = 2,
  parameter int BYPASS   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_RD-1:0][INDEX-1:0]     addr_i,
  output logic [NUM_RD-1:0][WIDTH-1:0]     data_o,
  input  logic [NUM_RD-1:0]                rdLaneActive_i,
  input  logic [NUM_WR-1:0][INDEX-1:0]     addrWr_i,
  input  logic [NUM_WR-1:0][WIDTH-1:0]     dataWr_i,
  input  logic [NUM_WR-1:0]                wrEn_i,
  input  logic [NUM_WR-1:0]                wrLaneActive_i,
  input  logic [PARTS-1:0]                 partActive_i,
  output logic                             ramReady_o,
  output logic [PARTS-1:0]                 initBusyPart_o
);
  localparam logic [1:0] INIT_ALL  = 2'd0;
  localparam logic [1:0] READY     = 2'd1;
  localparam logic [1:0] INIT_PART = 2'd2;
  localparam int ROW_BITS = INDEX - PART_LOG;
  localparam logic [ROW_BITS-1:0] ROW_ZERO = '0;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [1:0]          state, state_nxt;
  logic [INDEX-1:0]    cnt, cnt_nxt;
  logic [PARTS-1:0]    pending, pend_nxt, prev_active, rise, fall;
  logic [PART_LOG-1:0] cur_part, first_pend;
  logic                last_row, sweep_we;
  logic [NUM_WR-1:0]   we;
  assign rise           = partActive_i & ~prev_active;
  assign fall           = ~partActive_i & prev_active;
  assign cur_part       = cnt[INDEX-1 -: PART_LOG];
  assign last_row       = &cnt[ROW_BITS-1:0];
  assign ramReady_o     = state == READY;
  assign initBusyPart_o = state == INIT_ALL ? '1 : state == INIT_PART ? PARTS'(1) << cur_part : '0;
  always_comb begin
    we = '0;
    for (int p = 0; p < NUM_WR; p++)
      we[p] = wrEn_i[p] & wrLaneActive_i[p] & partActive_i[addrWr_i[p][INDEX-1 -: PART_LOG]] & ramReady_o;
  end
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sweep_we   = 1'b0;
    pend_nxt   = (pending | rise) & ~fall;
    first_pend = '0;
    for (int k = PARTS - 1; k >= 0; k--)
      if (pend_nxt[k]) first_pend = PART_LOG'(k);
    if (state == INIT_ALL) begin
      // inactive partitions are hopped over whole; their activation edge sweeps them later
      pend_nxt = '0;
      sweep_we = partActive_i[cur_part];
      cnt_nxt  = sweep_we ? cnt + 1'b1 : {cur_part + PART_LOG'(1), ROW_ZERO};
      if (sweep_we ? &cnt : &cur_part) state_nxt = READY;
    end else if (state == INIT_PART) begin
      sweep_we = ~fall[cur_part];
      cnt_nxt  = cnt + 1'b1;
      if (fall[cur_part] | last_row) state_nxt = READY;
      if (last_row) pend_nxt[cur_part] = 1'b0;
    end else if (|pend_nxt) begin
      state_nxt = INIT_PART;
      cnt_nxt   = {first_pend, ROW_ZERO};
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT_ALL;
      cnt         <= '0;
      pending     <= '0;
      prev_active <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pending     <= pend_nxt;
      prev_active <= partActive_i;
    end
  end
  always_ff @(posedge clk) begin
    if (sweep_we) mem[cnt] <= '0;
    for (int p = 0; p < NUM_WR; p++)
      if (we[p]) mem[addrWr_i[p]] <= dataWr_i[p];
  end
  always_comb begin
    data_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      data_o[r] = mem[addr_i[r]];
      if (BYPASS != 0)
        for (int p = 0; p < NUM_WR; p++)
          if (we[p] && addrWr_i[p] == addr_i[r]) data_o[r] = dataWr_i[p];
      if (!(rdLaneActive_i[r] && partActive_i[addr_i[r][INDEX-1 -: PART_LOG]])) data_o[r] = '0;
    end
  end
endmodule

// File: tb/tb_iq_payload_ram_cfg.sv
// tb_iq_payload_ram_cfg: directed checks of init sweeps, write priority, bypass and read masking
module tb_iq_payload_ram_cfg;
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0][5:0]  addr_i = '0;
  logic [3:0][31:0] data_o, data_b;
  logic [3:0]       rd_lane = 4'hf;
  logic [3:0][5:0]  addr_wr = '0;
  logic [3:0][31:0] data_wr = '0;
  logic [3:0]       wr_en = '0;
  logic [3:0]       wr_lane = 4'hf;
  logic [3:0]       part_act = 4'hf;
  logic             ready, ready_b;
  logic [3:0]       busy, busy_b;
  int               checks = 0;
  int               errors = 0;
  int               n, low;
  logic [3:0]       busy_t1, busy_t17, busy_t18;
  logic             ready_t17;
  always #5 clk = ~clk;
  iq_payload_ram_cfg dut (
    .clk(clk), .reset(reset), .addr_i(addr_i), .data_o(data_o), .rdLaneActive_i(rd_lane),
    .addrWr_i(addr_wr), .dataWr_i(data_wr), .wrEn_i(wr_en), .wrLaneActive_i(wr_lane),
    .partActive_i(part_act), .ramReady_o(ready), .initBusyPart_o(busy)
  );
  iq_payload_ram_cfg #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .addr_i(addr_i), .data_o(data_b), .rdLaneActive_i(rd_lane),
    .addrWr_i(addr_wr), .dataWr_i(data_wr), .wrEn_i(wr_en), .wrLaneActive_i(wr_lane),
    .partActive_i(part_act), .ramReady_o(ready_b), .initBusyPart_o(busy_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input int exp_cycles, input string tag);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
      wr_en = (n == 10) ? 4'b0001 : 4'b0000;
    end
    check(tag, n, exp_cycles);
  endtask
  initial begin
    addr_wr[0] = 6'd7;
    data_wr[0] = 32'hdead;
    tick();
    tick();
    check("reset_ready", {31'b0, ready}, 0);
    check("reset_busy", {28'b0, busy}, 32'hf);
    reset = 1'b1;
    wait_ready(64, "init_all_cycles");
    check("ready_b", {31'b0, ready_b}, 1);
    check("busy_after_init", {28'b0, busy}, 0);
    for (int r = 0; r < 64; r += 4) begin
      for (int q = 0; q < 4; q++) addr_i[q] = 6'(r + q);
      #1;
      for (int q = 0; q < 4; q++) check("init_zero", data_o[q], 0);
    end
    addr_i[0] = 6'd7;
    #1;
    check("dropped_write", data_o[0], 0);
    addr_i[0] = 6'd5;
    addr_wr[0] = 6'd5;
    data_wr[0] = 32'haaaa;
    addr_wr[3] = 6'd5;
    data_wr[3] = 32'hbbbb;
    wr_en = 4'b1001;
    #1;
    check("bypass_same_cycle", data_b[0], 32'hbbbb);
    check("no_bypass_same_cycle", data_o[0], 0);
    tick();
    wr_en = '0;
    #1;
    check("prio_next", data_o[0], 32'hbbbb);
    check("prio_next_b", data_b[0], 32'hbbbb);
    addr_wr[1] = 6'd2;
    data_wr[1] = 32'h1234;
    wr_en = 4'b0010;
    tick();
    wr_en = '0;
    addr_i = {6'd2, 6'd2, 6'd2, 6'd2};
    rd_lane = 4'b1011;
    #1;
    check("lane0", data_o[0], 32'h1234);
    check("lane1", data_o[1], 32'h1234);
    check("lane2_off", data_o[2], 0);
    check("lane3", data_o[3], 32'h1234);
    rd_lane = 4'hf;
    addr_wr[0] = 6'd20;
    data_wr[0] = 32'h55;
    wr_en = 4'b0001;
    tick();
    wr_en = '0;
    addr_i[0] = 6'd20;
    #1;
    check("row20_written", data_o[0], 32'h55);
    part_act = 4'b1101;
    #1;
    check("row20_masked", data_o[0], 0);
    tick();
    part_act = 4'hf;
    #1;
    check("ready_before_edge", {31'b0, ready}, 1);
    n = 0;
    low = 0;
    while (n < 40) begin
      tick();
      n++;
      if (!ready && busy == 4'b0010) low++;
      if (ready) break;
    end
    check("part1_sweep_cycles", low, 16);
    check("part1_done", {31'b0, ready}, 1);
    check("row20_cleared", data_o[0], 0);
    part_act = 4'b0011;
    tick();
    part_act = 4'hf;
    low = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (!ready) low++;
      if (t == 1) busy_t1 = busy;
      if (t == 17) begin busy_t17 = busy; ready_t17 = ready; end
      if (t == 18) busy_t18 = busy;
    end
    check("part23_low", low, 32);
    check("part2_first", {28'b0, busy_t1}, 32'h4);
    check("between_sweeps_busy", {28'b0, busy_t17}, 0);
    check("between_sweeps_ready", {31'b0, ready_t17}, 1);
    check("part3_second", {28'b0, busy_t18}, 32'h8);
    check("part23_done", {31'b0, ready}, 1);
    addr_i[0] = 6'd5;
    part_act = 4'b1110;
    tick();
    part_act = 4'hf;
    for (int t = 0; t < 8; t++) tick();
    check("mid_sweep_busy", {28'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("async_reset_ready", {31'b0, ready}, 0);
    check("async_reset_busy", {28'b0, busy}, 32'hf);
    tick();
    reset = 1'b1;
    addr_wr[0] = 6'd7;
    data_wr[0] = 32'hdead;
    wait_ready(64, "reinit_cycles");
    #1;
    check("row5_reinit", data_o[0], 0);
    addr_i[0] = 6'd7;
    #1;
    check("row7_still_zero", data_o[0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
